// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC and selects the next PC from the
// sequential, branch, jump or exception-vector sources. It also flags
// misaligned redirect targets.
module pc_fetch_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic             misaligned
);

  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             target_bad;

  // Jump wins over branch when both are asserted.
  always_comb begin
    redirect   = jump | branch_taken;
    target     = jump ? jump_target : branch_target;
    target_bad = |target[1:0];
  end

  assign PC4 = PC + WIDTH'(4);

  always_ff @(posedge clock) begin
    if (reset) begin
      PC         <= RESET_PC;
      misaligned <= 1'b0;
    end else if (redirect) begin
      PC         <= target_bad ? EXC_VECTOR : target;
      misaligned <= target_bad;
    end else if (stall) begin
      misaligned <= 1'b0;
    end else begin
      PC         <= PC4;
      misaligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit. A second instance
// covers a RESET_PC value at the top of the address space.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misaligned;

  logic        reset2;
  logic [31:0] pc_b;
  logic [31:0] pc4_b;
  logic        misaligned_b;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .PC(pc), .PC4(pc4), .misaligned(misaligned)
  );

  pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .EXC_VECTOR(32'h0000_0080)) dut_top (
    .clock(clock), .reset(reset2), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jump(1'b0), .jump_target(32'h0),
    .PC(pc_b), .PC4(pc4_b), .misaligned(misaligned_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            rst   stl   br    bt            jmp   jt            pc            pc4           mis
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0004, 32'h0000_0008, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_000C, 32'h0000_0010, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h100,      1'b1, 32'h200,      32'h0000_0200, 32'h0000_0204, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h102,      1'b0, 32'h0,        32'h0000_0080, 32'h0000_0084, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0084, 32'h0000_0088, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h500,      1'b1, 32'h43,       32'h0000_0080, 32'h0000_0084, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h41,       32'h0000_0080, 32'h0000_0084, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0080, 32'h0000_0084, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h0000_0040, 32'h0000_0044, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 32'h103,      1'b1, 32'h201,      32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h300,      1'b0, 32'h0,        32'h0000_0300, 32'h0000_0304, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'h0000_0004, 1'b0};

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; reset2 = 1'b1;

    for (int i = 0; i < 19; i++) begin
      reset         = vecs[i].rst;
      stall         = vecs[i].stl;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].bt;
      jump          = vecs[i].jmp;
      jump_target   = vecs[i].jt;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_pc", i),  pc,  vecs[i].exp_pc);
      chk($sformatf("v%0d_pc4", i), pc4, vecs[i].exp_pc4);
      chk($sformatf("v%0d_mis", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
    end

    // Top-of-memory reset value: PC4 wraps to zero, then PC follows it.
    chk("top_rst_pc",  pc_b,  32'hFFFF_FFFC);
    chk("top_rst_pc4", pc4_b, 32'h0000_0000);
    chk("top_rst_mis", {31'b0, misaligned_b}, 32'h0);
    reset2 = 1'b0;
    @(posedge clock);
    #1;
    chk("top_wrap_pc",  pc_b,  32'h0000_0000);
    chk("top_wrap_pc4", pc4_b, 32'h0000_0004);
    @(posedge clock);
    #1;
    chk("top_next_pc",  pc_b,  32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
